chess_timer_fsm: RTL
====================

CHESS_TIMER_FSM -- requirements
Module: chess_timer_fsm

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, i_clk cycles per one-second tick (legal range 2..2^26).
REQ-002 Parameter INIT_TIME, default 10'd300, per-player starting time in seconds (legal range 1..999).
REQ-003 i_clk  input  1  system clock, 50 MHz on board; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_key_start  input  1  raw pushbutton, active-low, asynchronous to i_clk.
REQ-006 i_key_p1  input  1  player-1 turn-end pushbutton, raw, active-low, asynchronous.
REQ-007 i_key_p2  input  1  player-2 turn-end pushbutton, raw, active-low, asynchronous.
REQ-008 i_pause  input  1  slide switch, level, 1 = clock frozen.
REQ-009 o_counter_1  output  10  player-1 remaining seconds, unsigned binary.
REQ-010 o_counter_2  output  10  player-2 remaining seconds, unsigned binary.
REQ-011 o_state_displays  output  2  00 IDLE, 01 P1_RUN, 10 P2_RUN, 11 DONE; drives the display controller directly.
REQ-012 o_tick  output  1  one-cycle pulse on every prescaler tick that decrements a counter.

Function
REQ-013 Each key SHALL pass a 2-flop synchronizer and a press detector (registered previous value 1, synchronized value 0) producing a one-cycle press pulse per high-to-low transition.
REQ-014 A key press SHALL change state on the 3rd rising edge of i_clk counting the edge that first samples the key low; holding a key SHALL produce exactly one press.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 only in P1_RUN or P2_RUN with i_pause=0, asserting tick when at TICK_DIV-1 and wrapping to 0.
REQ-016 Prescaler SHALL hold its value while i_pause=1 and SHALL clear to 0 on every state transition.
REQ-017 IDLE: counters held at INIT_TIME; start press -> P1_RUN; p1/p2 presses ignored.
REQ-018 P1_RUN: tick decrements o_counter_1 by 1; p1 press (i_pause=0) -> P2_RUN; p2 press ignored.
REQ-019 P2_RUN: tick decrements o_counter_2 by 1; p2 press (i_pause=0) -> P1_RUN; p1 press ignored.
REQ-020 A tick with the active counter equal to 1 SHALL write 0 and enter DONE on the same edge.
REQ-021 Tick-to-zero and turn-end press in the same cycle: DONE wins, press discarded.
REQ-022 Counters SHALL never underflow; a zero counter is never decremented.
REQ-023 While i_pause=1, player presses SHALL be ignored; start press still acts in IDLE and DONE.
REQ-024 DONE: counters frozen (loser holds 0); start press -> IDLE with both counters reloaded to INIT_TIME on the same edge.
REQ-025 Start press during P1_RUN or P2_RUN SHALL be ignored.
REQ-026 o_tick SHALL be high exactly in the cycle following the edge at which the counter decremented, and low otherwise.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 i_rst=1 at a rising edge SHALL force state IDLE, o_counter_1=o_counter_2=INIT_TIME, prescaler 0, o_tick 0, synchronizer and previous-value flops 1 (released).
REQ-029 Reset SHALL override every other input in the same cycle, including mid-run and in DONE.
REQ-030 A key held low through reset release SHALL NOT generate a press until released and pressed again.

Verification (TICK_DIV=4, INIT_TIME=3)
REQ-031 Reset, start press -> o_state_displays 01 at 3rd edge; after 4 clocks o_counter_1=2, o_tick pulses once.
REQ-032 P1_RUN, p1 press -> 10, prescaler restarts, o_counter_1 unchanged; p1 press again ignored; p2 press -> 01.
REQ-033 P1_RUN with o_counter_1=1, p1 press timed to same cycle as tick -> o_counter_1=0, state 11, o_counter_2 unchanged.
REQ-034 i_pause=1 for 20 clocks in P2_RUN -> o_counter_2 and state constant, p2 press ignored; release resumes from held prescaler value.
REQ-035 DONE, start press -> state 00, both counters 3; i_rst asserted mid P2_RUN -> next edge state 00, counters 3.
REQ-036 Key held low across reset deassertion -> state stays 00 until key released and pressed again.

Source files
------------

// File: rtl/chess_timer_fsm.sv
// Two-player chess clock: debounced-by-synchronizer key presses, a one-second
// prescaler, and a four-state turn controller with per-player countdowns.
`timescale 1ns/1ps
module chess_timer_fsm #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter logic [9:0]  INIT_TIME = 10'd300
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_start,
    input  logic       i_key_p1,
    input  logic       i_key_p2,
    input  logic       i_pause,
    output logic [9:0] o_counter_1,
    output logic [9:0] o_counter_2,
    output logic [1:0] o_state_displays,
    output logic       o_tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        P1_RUN = 2'b01,
        P2_RUN = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t        state, state_nxt;
    logic [9:0]    cnt_1, cnt_2, cnt_1_nxt, cnt_2_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          running, tick, dec;

    // Key bit order: {p2, p1, start}
    logic [2:0] key_raw, sync1, sync2, prev, armed, press;
    logic [1:0] rst_age;

    assign key_raw = {i_key_p2, i_key_p1, i_key_start};
    // A key only arms once it has been seen released after reset, so a key held
    // through reset release cannot masquerade as a fresh press.
    assign press   = armed & prev & ~sync2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1   <= '1;
            sync2   <= '1;
            prev    <= '1;
            armed   <= '0;
            rst_age <= '0;
        end else begin
            sync1   <= key_raw;
            sync2   <= sync1;
            prev    <= sync2;
            rst_age <= {rst_age[0], 1'b1};
            if (rst_age[1]) armed <= armed | sync2;
        end
    end

    assign running = ((state == P1_RUN) || (state == P2_RUN)) && !i_pause;
    assign tick    = running && (presc == PRE_MAX);

    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_1_nxt = cnt_1;
        cnt_2_nxt = cnt_2;
        dec       = 1'b0;
        case (state)
            IDLE: begin
                cnt_1_nxt = INIT_TIME;
                cnt_2_nxt = INIT_TIME;
                if (press[0]) state_nxt = P1_RUN;
            end
            P1_RUN: begin
                if (tick && cnt_1 != 10'd0) begin
                    dec       = 1'b1;
                    cnt_1_nxt = cnt_1 - 10'd1;
                    if (cnt_1 == 10'd1) state_nxt = DONE;
                end
                if (state_nxt != DONE && press[1] && !i_pause) state_nxt = P2_RUN;
            end
            P2_RUN: begin
                if (tick && cnt_2 != 10'd0) begin
                    dec       = 1'b1;
                    cnt_2_nxt = cnt_2 - 10'd1;
                    if (cnt_2 == 10'd1) state_nxt = DONE;
                end
                if (state_nxt != DONE && press[2] && !i_pause) state_nxt = P1_RUN;
            end
            DONE: begin
                if (press[0]) begin
                    state_nxt = IDLE;
                    cnt_1_nxt = INIT_TIME;
                    cnt_2_nxt = INIT_TIME;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state) presc_nxt = '0;
        else if (running)       presc_nxt = (presc == PRE_MAX) ? '0 : presc + 1'b1;
        else                    presc_nxt = presc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt_1  <= INIT_TIME;
            cnt_2  <= INIT_TIME;
            presc  <= '0;
            o_tick <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt_1  <= cnt_1_nxt;
            cnt_2  <= cnt_2_nxt;
            presc  <= presc_nxt;
            o_tick <= dec;
        end
    end

    assign o_state_displays = state;
    assign o_counter_1      = cnt_1;
    assign o_counter_2      = cnt_2;

endmodule
